// File: rtl/sequence_playback_unit.sv
// Ordered capture buffer for strobed 4-bit values, replayed to the display
// path with timed show/gap intervals.
module sequence_playback_unit #(
    parameter int DEPTH       = 8,
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000,
    localparam int LEN_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       num_in,
    input  logic             num_valid,
    input  logic             play_start,
    input  logic             clear,
    output logic [3:0]       disp_num,
    output logic             disp_valid,
    output logic             play_busy,
    output logic             play_done,
    output logic [LEN_W-1:0] seq_len,
    output logic             seq_full
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] seq_len_q, seq_len_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       disp_num_q, disp_num_d;
    logic             disp_valid_q, disp_valid_d;
    logic             play_busy_q, play_busy_d;
    logic             play_done_q, play_done_d;
    logic             seq_full_q, seq_full_d;
    logic [3:0]       mem_q [DEPTH];
    logic [3:0]       mem_d [DEPTH];
    logic             capture;

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        seq_len_d    = seq_len_q;
        index_d      = index_q;
        cnt_d        = cnt_q;
        disp_num_d   = disp_num_q;
        disp_valid_d = disp_valid_q;
        play_busy_d  = play_busy_q;
        play_done_d  = 1'b0;
        mem_d        = mem_q;
        capture      = (state_q == IDLE) && num_valid && !clear
                       && (seq_len_q < LEN_W'(DEPTH));

        if (clear) begin
            state_d      = IDLE;
            seq_len_d    = '0;
            index_d      = '0;
            cnt_d        = '0;
            disp_num_d   = 4'd0;
            disp_valid_d = 1'b0;
            play_busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        mem_d[seq_len_q[IDX_W-1:0]] = num_in;
                        seq_len_d = seq_len_q + LEN_W'(1);
                    end
                    if (play_start) begin
                        index_d     = '0;
                        cnt_d       = '0;
                        play_busy_d = 1'b1;
                        if (seq_len_d != '0) begin
                            state_d      = SHOW;
                            disp_num_d   = mem_d[0];
                            disp_valid_d = 1'b1;
                        end else begin
                            state_d     = DONE;
                            play_done_d = 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                        state_d      = GAP;
                        cnt_d        = '0;
                        disp_num_d   = 4'd0;
                        disp_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (LEN_W'(index_q) == seq_len_q - LEN_W'(1)) begin
                            state_d     = DONE;
                            play_done_d = 1'b1;
                        end else begin
                            state_d      = SHOW;
                            index_d      = index_q + IDX_W'(1);
                            disp_num_d   = mem_q[index_q + IDX_W'(1)];
                            disp_valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d     = IDLE;
                    play_busy_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
        seq_full_d = (seq_len_d == LEN_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            seq_len_q    <= '0;
            index_q      <= '0;
            cnt_q        <= '0;
            disp_num_q   <= 4'd0;
            disp_valid_q <= 1'b0;
            play_busy_q  <= 1'b0;
            play_done_q  <= 1'b0;
            seq_full_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_len_q    <= seq_len_d;
            index_q      <= index_d;
            cnt_q        <= cnt_d;
            disp_num_q   <= disp_num_d;
            disp_valid_q <= disp_valid_d;
            play_busy_q  <= play_busy_d;
            play_done_q  <= play_done_d;
            seq_full_q   <= seq_full_d;
        end
    end

    // Buffer storage has no reset; seq_len alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    assign disp_num   = disp_num_q;
    assign disp_valid = disp_valid_q;
    assign play_busy  = play_busy_q;
    assign play_done  = play_done_q;
    assign seq_len    = seq_len_q;
    assign seq_full   = seq_full_q;

endmodule

// File: tb/tb_sequence_playback_unit.sv
// Bench for sequence_playback_unit: fixed vector table, directed corner
// sequences and a randomized run against a timeline reference model.
module tb_sequence_playback_unit;

    localparam int DEPTH = 4;
    localparam int SHOW  = 3;
    localparam int GAPC  = 2;
    localparam int PER   = SHOW + GAPC;

    logic       clk;
    logic       rst;
    logic [3:0] num_in;
    logic       num_valid;
    logic       play_start;
    logic       clear;
    logic [3:0] disp_num;
    logic       disp_valid;
    logic       play_busy;
    logic       play_done;
    logic [2:0] seq_len;
    logic       seq_full;

    sequence_playback_unit #(
        .DEPTH(DEPTH),
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES(GAPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .num_in(num_in),
        .num_valid(num_valid),
        .play_start(play_start),
        .clear(clear),
        .disp_num(disp_num),
        .disp_valid(disp_valid),
        .play_busy(play_busy),
        .play_done(play_done),
        .seq_len(seq_len),
        .seq_full(seq_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit r;
        bit nv;
        int num;
        bit ps;
        bit clr;
        int e_num;
        bit e_val;
        bit e_busy;
        bit e_done;
        int e_len;
        bit e_full;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: stored values plus a replay timeline position.
    int m_q[$];
    bit m_busy;
    int m_t;
    int m_n;

    // Observation helpers for the directed sequences.
    int shown[$];
    int done_cnt;
    bit prev_val;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit nv, input int num, input bit ps, input bit clr);
        if (r || clr) begin
            m_q.delete();
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_t == m_n * PER + 1) m_busy = 1'b0;
            else m_t++;
        end else begin
            if (nv && m_q.size() < DEPTH) m_q.push_back(num);
            if (ps) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_n    = m_q.size();
            end
        end
    endtask

    task automatic model_check();
        int e_num, e_val, e_busy, e_done;
        e_num = 0; e_val = 0; e_busy = 0; e_done = 0;
        if (m_busy) begin
            e_busy = 1;
            if (m_t <= m_n * PER) begin
                if ((m_t - 1) % PER < SHOW) begin
                    e_val = 1;
                    e_num = m_q[(m_t - 1) / PER];
                end
            end else begin
                e_done = 1;
            end
        end
        checkOutput("m_disp_num", int'(disp_num), e_num);
        checkOutput("m_disp_valid", int'(disp_valid), e_val);
        checkOutput("m_play_busy", int'(play_busy), e_busy);
        checkOutput("m_play_done", int'(play_done), e_done);
        checkOutput("m_seq_len", int'(seq_len), m_q.size());
        checkOutput("m_seq_full", int'(seq_full), int'(m_q.size() == DEPTH));
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge,
    // compare at the next falling edge.
    task automatic applyStimulus(input bit r, input bit nv, input int num, input bit ps, input bit clr);
        rst        = r;
        num_valid  = nv;
        num_in     = 4'(num);
        play_start = ps;
        clear      = clr;
        @(posedge clk);
        model_update(r, nv, num, ps, clr);
        @(negedge clk);
        model_check();
        if (disp_valid && !prev_val) shown.push_back(int'(disp_num));
        if (play_done) done_cnt++;
        prev_val = disp_valid;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic reset_obs();
        shown.delete();
        done_cnt = 0;
    endtask

    function automatic vec_t mk(bit r, bit nv, int num, bit ps, bit clr,
                                int en, bit ev, bit eb, bit ed, int el, bit ef);
        vec_t v;
        v.r = r; v.nv = nv; v.num = num; v.ps = ps; v.clr = clr;
        v.e_num = en; v.e_val = ev; v.e_busy = eb; v.e_done = ed;
        v.e_len = el; v.e_full = ef;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int vals[3];
        rst = 1'b0; num_valid = 1'b0; num_in = 4'd0; play_start = 1'b0; clear = 1'b0;
        m_busy = 1'b0; m_t = 0; m_n = 0;
        prev_val = 1'b0;
        reset_obs();

        // Vector table: reset, capture, clear, then a full 3-entry replay.
        vals = '{3, 9, 12};
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 0, 0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 9, 0, 0,  0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 12, 0, 0, 0, 0, 0, 0, 3, 0));
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < SHOW; k++)
                tbl.push_back(mk(0, 0, 0, (e == 0 && k == 0), 0, vals[e], 1, 1, 0, 3, 0));
            for (int k = 0; k < GAPC; k++)
                tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].nv, tbl[i].num, tbl[i].ps, tbl[i].clr);
            checkOutput($sformatf("tbl%0d_disp_num", i), int'(disp_num), tbl[i].e_num);
            checkOutput($sformatf("tbl%0d_disp_valid", i), int'(disp_valid), int'(tbl[i].e_val));
            checkOutput($sformatf("tbl%0d_busy", i), int'(play_busy), int'(tbl[i].e_busy));
            checkOutput($sformatf("tbl%0d_done", i), int'(play_done), int'(tbl[i].e_done));
            checkOutput($sformatf("tbl%0d_len", i), int'(seq_len), tbl[i].e_len);
            checkOutput($sformatf("tbl%0d_full", i), int'(seq_full), int'(tbl[i].e_full));
        end

        // Overfill: fifth strobe dropped, replay shows only the first four.
        applyStimulus(1, 0, 0, 0, 0);
        for (int v = 1; v <= 5; v++) applyStimulus(0, 1, v, 0, 0);
        checkOutput("over_len", int'(seq_len), 4);
        checkOutput("over_full", int'(seq_full), 1);
        reset_obs();
        applyStimulus(0, 0, 0, 1, 0);
        idle_steps(4 * PER + 1);
        checkOutput("over_count", shown.size(), 4);
        for (int i = 0; i < 4 && i < shown.size(); i++)
            checkOutput($sformatf("over_val%0d", i), shown[i], i + 1);
        checkOutput("over_done", done_cnt, 1);

        // Same-cycle capture and start; strobe during SHOW dropped.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 0, 0);
        applyStimulus(0, 1, 8, 0, 0);
        reset_obs();
        applyStimulus(0, 1, 6, 1, 0);
        checkOutput("same_len", int'(seq_len), 3);
        checkOutput("same_first", int'(disp_num), 7);
        checkOutput("same_valid", int'(disp_valid), 1);
        applyStimulus(0, 1, 2, 0, 0);
        checkOutput("show_drop_len", int'(seq_len), 3);
        idle_steps(3 * PER);
        checkOutput("same_count", shown.size(), 3);
        if (shown.size() == 3) begin
            checkOutput("same_v0", shown[0], 7);
            checkOutput("same_v1", shown[1], 8);
            checkOutput("same_v2", shown[2], 6);
        end
        checkOutput("same_done", done_cnt, 1);

        // Clear during second SHOW, then replay of an empty buffer.
        applyStimulus(1, 0, 0, 0, 0);
        for (int v = 10; v < 13; v++) applyStimulus(0, 1, v, 0, 0);
        reset_obs();
        applyStimulus(0, 0, 0, 1, 0);
        idle_steps(PER);
        checkOutput("clr_pre_num", int'(disp_num), 11);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("clr_valid", int'(disp_valid), 0);
        checkOutput("clr_len", int'(seq_len), 0);
        checkOutput("clr_busy", int'(play_busy), 0);
        idle_steps(3);
        checkOutput("clr_no_done", done_cnt, 0);
        reset_obs();
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("empty_done", int'(play_done), 1);
        checkOutput("empty_busy", int'(play_busy), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("empty_done_end", int'(play_done), 0);
        checkOutput("empty_never_shown", shown.size(), 0);

        // Reset mid-GAP together with a strobe.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 0);
        applyStimulus(0, 1, 5, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        idle_steps(SHOW);
        checkOutput("gap_check_valid", int'(disp_valid), 0);
        checkOutput("gap_check_busy", int'(play_busy), 1);
        applyStimulus(1, 1, 9, 0, 0);
        checkOutput("rst_busy", int'(play_busy), 0);
        checkOutput("rst_len", int'(seq_len), 0);
        checkOutput("rst_valid", int'(disp_valid), 0);
        checkOutput("rst_num", int'(disp_num), 0);

        // Randomized run against the timeline model.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(15),
                          $urandom_range(9) == 0, $urandom_range(59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
